// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 size/sign encodings, FSM state
// encoding, lane count and the legality check used at request acceptance.
package load_store_unit_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumLanes  = DataWidth / 8;

  // Load funct3 encodings
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

  // True when the funct3 encoding exists for this op type and the byte offset is naturally
  // aligned for the access size.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3Sb:    ok = 1'b1;
        F3Sh:    ok = ~offset[0];
        F3Sw:    ok = (offset == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3Lb, F3Lbu: ok = 1'b1;
        F3Lh, F3Lhu: ok = ~offset[0];
        F3Lw:        ok = (offset == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load-data alignment: selects the byte/halfword lane addressed by offset from a
// read word and sign- or zero-extends it according to funct3.
//   rdata  - word returned by memory
//   offset - addr[1:0] of the access
//   funct3 - load size/sign encoding
//   result - extended load value
module lsu_load_extract
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (offset)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    // Halfword accesses are aligned, so only offset[1] picks the lane
    lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3Lb:    result = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
      F3Lbu:   result = {{(WIDTH-8){1'b0}}, lane_byte};
      F3Lh:    result = {{(WIDTH-16){lane_half[15]}}, lane_half};
      F3Lhu:   result = {{(WIDTH-16){1'b0}}, lane_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts an EX-stage load/store, issues one data-memory transaction,
// and returns aligned, extended load data (the writeback data_read operand) with a one-cycle
// rsp_valid pulse. Illegal or misaligned accesses complete without touching memory.
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake from EX
//   mem_read, mem_write, funct3      - op type and access size/sign
//   addr, store_data                 - byte address and rs2 value
//   rsp_valid, load_data, access_err - completion pulse, load result, error flag
//   stall                            - hold upstream while busy
//   dmem_*                           - data-memory request/response interface
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  input  logic [WIDTH-1:0]    addr,
  input  logic [WIDTH-1:0]    store_data,
  output logic                rsp_valid,
  output logic [WIDTH-1:0]    load_data,
  output logic                access_err,
  output logic                stall,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_we,
  output logic [WIDTH-1:0]    dmem_addr,
  output logic [WIDTH-1:0]    dmem_wdata,
  output logic [NumLanes-1:0] dmem_wstrb,
  input  logic                dmem_rsp_valid,
  input  logic [WIDTH-1:0]    dmem_rdata
);

  lsu_state_e state_q, state_d;

  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] store_data_q;
  logic [WIDTH-1:0] load_data_q;
  logic             is_store_q;
  logic             err_q;

  logic                req_accept;
  logic                req_legal;
  logic [WIDTH-1:0]    extract_result;
  logic [WIDTH-1:0]    store_wdata;
  logic [NumLanes-1:0] store_wstrb;

  assign req_accept = (state_q == StIdle) && req_valid && (mem_read || mem_write);
  assign req_legal  = access_legal(mem_write, funct3, addr[1:0]);

  lsu_load_extract #(
    .WIDTH (WIDTH)
  ) u_load_extract (
    .rdata  (dmem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (extract_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_accept) begin
          state_d = req_legal ? StReq : StResp;
        end
      end
      StReq: begin
        if (dmem_req_ready) begin
          state_d = is_store_q ? StResp : StWait;
        end
      end
      StWait: begin
        if (dmem_rsp_valid) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture and load result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      is_store_q   <= 1'b0;
      err_q        <= 1'b0;
      load_data_q  <= '0;
    end else begin
      if (req_accept) begin
        funct3_q     <= funct3;
        addr_q       <= addr;
        store_data_q <= store_data;
        is_store_q   <= mem_write;
        err_q        <= ~req_legal;
      end
      // Store and error responses present zero load data
      if (req_accept && !req_legal) begin
        load_data_q <= '0;
      end else if ((state_q == StReq) && dmem_req_ready && is_store_q) begin
        load_data_q <= '0;
      end else if ((state_q == StWait) && dmem_rsp_valid) begin
        load_data_q <= extract_result;
      end
    end
  end

  // Store lane steering: narrow data is replicated so every enabled lane carries it
  always_comb begin
    store_wstrb = 4'b1111;
    store_wdata = store_data_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_wstrb = 4'b0001 << addr_q[1:0];
        store_wdata = {4{store_data_q[7:0]}};
      end
      2'b01: begin
        store_wstrb = 4'b0011 << addr_q[1:0];
        store_wdata = {2{store_data_q[15:0]}};
      end
      default: begin
        store_wstrb = 4'b1111;
        store_wdata = store_data_q;
      end
    endcase
  end

  // Outputs
  always_comb begin
    req_ready      = (state_q == StIdle);
    stall          = (state_q != StIdle) || (req_valid && (mem_read || mem_write));
    rsp_valid      = (state_q == StResp);
    access_err     = (state_q == StResp) && err_q;
    load_data      = load_data_q;
    dmem_req_valid = (state_q == StReq);
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_wstrb     = '0;
    if (state_q == StReq) begin
      dmem_we   = is_store_q;
      dmem_addr = {addr_q[WIDTH-1:2], 2'b00};
      if (is_store_q) begin
        dmem_wdata = store_wdata;
        dmem_wstrb = store_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        req_ready, rsp_valid, access_err, stall;
  logic        dmem_req_valid, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_req_ready, dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  int n_tests = 0;
  int n_fail = 0;

  // Memory model controls
  int          ready_delay = 0;
  int          rsp_delay = 0;
  logic [31:0] mem_word = '0;
  int          ready_wait_cnt;
  int          rsp_cnt;
  logic        pending;

  always #5 clk = ~clk;

  load_store_unit #(
    .WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .rsp_valid      (rsp_valid),
    .load_data      (load_data),
    .access_err     (access_err),
    .stall          (stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata)
  );

  // Data memory: ready after ready_delay waiting cycles, read response rsp_delay cycles after
  // the first cycle following acceptance. Read data is garbage outside the response cycle.
  assign dmem_req_ready = dmem_req_valid && (ready_wait_cnt >= ready_delay);
  assign dmem_rsp_valid = pending && (rsp_cnt >= rsp_delay);
  assign dmem_rdata     = dmem_rsp_valid ? mem_word : 32'hBAD0_BAD0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_wait_cnt <= 0;
      rsp_cnt        <= 0;
      pending        <= 1'b0;
    end else begin
      if (dmem_req_valid && !dmem_req_ready) ready_wait_cnt <= ready_wait_cnt + 1;
      if (pending) begin
        if (dmem_rsp_valid) pending <= 1'b0;
        else rsp_cnt <= rsp_cnt + 1;
      end
      if (dmem_req_valid && dmem_req_ready) begin
        ready_wait_cnt <= 0;
        if (!dmem_we) begin
          pending <= 1'b1;
          rsp_cnt <= 0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation and check handshake, memory request, latency and response.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_ld, input logic exp_mem,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    int          lat;
    logic        seen_req, unstable, stall_low, got_err;
    logic [31:0] got_ld, h_addr, h_wdata;
    logic        h_we;
    logic [3:0]  h_wstrb;
    lat = 0; seen_req = 0; unstable = 0; stall_low = 0; got_err = 0;
    got_ld = '0; h_addr = '0; h_wdata = '0; h_we = 0; h_wstrb = '0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    #1;
    check_eq({tag, "/req_ready"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, "/stall_req"}, {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs so only captured values can reach memory
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b111; addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        got_err = access_err;
        got_ld = load_data;
        break;
      end
      if (!stall) stall_low = 1'b1;
      if (dmem_req_valid) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          h_addr = dmem_addr; h_we = dmem_we; h_wdata = dmem_wdata; h_wstrb = dmem_wstrb;
        end else if (dmem_addr !== h_addr || dmem_we !== h_we || dmem_wdata !== h_wdata ||
                     dmem_wstrb !== h_wstrb) begin
          unstable = 1'b1;
        end
      end
    end
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/mem_access"}, {31'b0, seen_req}, {31'b0, exp_mem});
    check_eq({tag, "/access_err"}, {31'b0, got_err}, {31'b0, exp_err});
    check_eq({tag, "/load_data"}, got_ld, exp_ld);
    check_eq({tag, "/stall_hold"}, {31'b0, stall_low}, 32'd0);
    if (exp_mem) begin
      check_eq({tag, "/dmem_addr"}, h_addr, exp_addr);
      check_eq({tag, "/dmem_we"}, {31'b0, h_we}, {31'b0, exp_we});
      check_eq({tag, "/req_stable"}, {31'b0, unstable}, 32'd0);
      if (exp_we) begin
        check_eq({tag, "/wdata"}, h_wdata, exp_wdata);
        check_eq({tag, "/wstrb"}, {28'b0, h_wstrb}, {28'b0, exp_wstrb});
      end
    end
    @(negedge clk);
    check_eq({tag, "/single_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "/ld_hold"}, load_data, exp_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    logic in_wait;
    // Reset
    #2 rst_n = 1'b0;
    #18;
    check_eq("rst/req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst/stall", {31'b0, stall}, 32'd0);
    check_eq("rst/dmem_req_valid", {31'b0, dmem_req_valid}, 32'd0);
    check_eq("rst/load_data", load_data, 32'd0);
    check_eq("rst/access_err", {31'b0, access_err}, 32'd0);
    check_eq("rst/dmem_wstrb", {28'b0, dmem_wstrb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait loads
    mem_word = 32'hDEAD_BEEF;
    run_op("lw", 1, 0, 3'b010, 32'h100, 0, 3, 0, 32'hDEAD_BEEF, 1, 32'h100, 0, 0, 0);
    mem_word = 32'h80AA_55CC;
    run_op("lb103", 1, 0, 3'b000, 32'h103, 0, 3, 0, 32'hFFFF_FF80, 1, 32'h100, 0, 0, 0);
    run_op("lbu103", 1, 0, 3'b100, 32'h103, 0, 3, 0, 32'h0000_0080, 1, 32'h100, 0, 0, 0);
    run_op("lb100", 1, 0, 3'b000, 32'h100, 0, 3, 0, 32'hFFFF_FFCC, 1, 32'h100, 0, 0, 0);
    run_op("lb101", 1, 0, 3'b000, 32'h101, 0, 3, 0, 32'h0000_0055, 1, 32'h100, 0, 0, 0);
    run_op("lh102", 1, 0, 3'b001, 32'h102, 0, 3, 0, 32'hFFFF_80AA, 1, 32'h100, 0, 0, 0);
    run_op("lhu100", 1, 0, 3'b101, 32'h100, 0, 3, 0, 32'h0000_55CC, 1, 32'h100, 0, 0, 0);

    // Stores
    run_op("sh0a", 0, 1, 3'b001, 32'h0A, 32'h1234_ABCD, 2, 0, 0, 1, 32'h08, 1,
           32'hABCD_ABCD, 4'b1100);
    run_op("sb01", 0, 1, 3'b000, 32'h01, 32'h0000_00A5, 2, 0, 0, 1, 32'h00, 1,
           32'hA5A5_A5A5, 4'b0010);
    run_op("sw10", 0, 1, 3'b010, 32'h10, 32'hCAFE_F00D, 2, 0, 0, 1, 32'h10, 1,
           32'hCAFE_F00D, 4'b1111);

    // Illegal / misaligned: no memory access, error response next cycle
    run_op("lw102", 1, 0, 3'b010, 32'h102, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_op("ld011", 1, 0, 3'b011, 32'h100, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_op("sd011", 0, 1, 3'b011, 32'h000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_op("sh05", 0, 1, 3'b001, 32'h005, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_op("lhu103", 1, 0, 3'b101, 32'h103, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Backpressured memory: 5 cycles not ready, response 3 cycles late
    ready_delay = 5; rsp_delay = 3; mem_word = 32'h0BAD_F00D;
    run_op("lw_slow", 1, 0, 3'b010, 32'h204, 0, 11, 0, 32'h0BAD_F00D, 1, 32'h204, 0, 0, 0);
    ready_delay = 0; rsp_delay = 0;

    // Request with neither read nor write: ignored
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
    #1;
    check_eq("nop/stall", {31'b0, stall}, 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || dmem_req_valid || !req_ready) seen++;
    end
    check_eq("nop/no_activity", seen, 0);
    req_valid = 1'b0;

    // Reset in the middle of a load wait
    rsp_delay = 10; mem_word = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0;
    in_wait = 1'b0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req_valid) begin
        seen = 1;
      end else if (seen == 1) begin
        in_wait = 1'b1;
        break;
      end
    end
    check_eq("rstwait/reached_wait", {31'b0, in_wait}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstwait/req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rstwait/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rstwait/dmem_req_valid", {31'b0, dmem_req_valid}, 32'd0);
    check_eq("rstwait/stall", {31'b0, stall}, 32'd0);
    check_eq("rstwait/load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_delay = 0; mem_word = 32'h7654_3210;
    run_op("lw_after_rst", 1, 0, 3'b010, 32'h104, 0, 3, 0, 32'h7654_3210, 1, 32'h104, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage block that turns an EX-stage load/store into a data-memory transaction and returns aligned, sign/zero-extended load data.
- Its load_data output is the data_read operand consumed by the writeback stage.
- Handles byte/halfword/word access per RISC-V funct3, a valid/ready request handshake and a valid response from data memory.
- Raises a pipeline stall while a transaction is in flight.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the alignment and strobe logic is written for 4 byte lanes.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX-stage memory operation present
- req_ready  out  1  unit can accept a request
- mem_read  in  1  operation is a load
- mem_write  in  1  operation is a store; mem_read and mem_write are never both 1
- funct3  in  3  access size/sign
- addr  in  WIDTH  byte address
- store_data  in  WIDTH  rs2 value, in the low bytes
- rsp_valid  out  1  one-cycle pulse: operation complete
- load_data  out  WIDTH  extended load result (to writeback data_read)
- access_err  out  1  valid with rsp_valid: misaligned access or illegal funct3
- stall  out  1  hold the upstream pipeline
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts the request
- dmem_we  out  1  write request
- dmem_addr  out  WIDTH  word-aligned address, addr with bits [1:0] forced to 0
- dmem_wdata  out  WIDTH  store data shifted to the byte lane
- dmem_wstrb  out  WIDTH/8  byte enables
- dmem_rsp_valid  in  1  read data valid
- dmem_rdata  in  WIDTH  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready = (state==IDLE).
- stall = (state!=IDLE) or (req_valid and (mem_read or mem_write)).
- Acceptance: in IDLE with req_valid and (mem_read or mem_write).
  - The unit captures funct3, addr, store_data and the op type into internal registers.
  - If the access is illegal, go to RESP with the error flag set; no memory access is made.
  - Otherwise go to REQ.
- Legal encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00. A misaligned access is illegal.
- REQ:
  - dmem_req_valid=1. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb come from the captured registers and stay stable until accepted.
  - When dmem_req_ready=1: a load goes to WAIT, a store goes to RESP.
- Store strobes and data:
  - SB: wstrb = 1 << addr[1:0]; wdata = byte replicated to all 4 lanes.
  - SH: wstrb = 0011 << addr[1:0]; wdata = halfword replicated.
  - SW: wstrb = 1111; wdata = store_data.
- WAIT: on dmem_rsp_valid, extract the lane selected by addr[1:0], sign- or zero-extend it, register the result into load_data, then go to RESP.
- dmem_rsp_valid outside WAIT is ignored. Memory returns the response no earlier than one cycle after acceptance.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - access_err reflects the error flag.
  - load_data holds its value until the next load response. On a store or error response, load_data is 0.
- Latency with a zero-wait memory (ready=1, response the next cycle), counted from the acceptance cycle:
  - Load: rsp_valid 3 cycles later.
  - Store: rsp_valid 2 cycles later.
  - Error: rsp_valid 1 cycle later.
- Requests with neither mem_read nor mem_write are not accepted and produce no response.
- Reset (asynchronous, any state including mid-transaction):
  - state=IDLE; all outputs 0 except req_ready=1.
  - Any outstanding memory request is abandoned; the memory must also be reset by the same rst_n.

Decomposition:
- Shared package holds:
  - funct3 load/store encodings (LB..SW).
  - FSM state encoding.
  - byte-lane count constant WIDTH/8.
- One natural sub-module, lsu_load_extract: combinational dmem_rdata + addr[1:0] + funct3 -> extended WIDTH-bit result. It is reusable by a future cache.

Test Plan:
- LW addr=0x100, memory returns 0xDEADBEEF with zero wait -> rsp_valid 3 cycles after acceptance; load_data=0xDEADBEEF; access_err=0; dmem_addr=0x100.
- LB at addr=0x103 and LBU at addr=0x103, rdata=0x80AA55CC -> LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH addr=0x0A, store_data=0x1234ABCD -> dmem_addr=0x08, wstrb=1100, wdata=0xABCDABCD, dmem_we=1; rsp_valid 2 cycles after acceptance.
- LW addr=0x102 -> no dmem_req_valid; rsp_valid the next cycle with access_err=1; funct3=011 behaves the same.
- dmem_req_ready held low 5 cycles, then the response delayed 3 cycles -> request stable through the wait; stall high throughout; single rsp_valid pulse at the end.
- rst_n asserted while in WAIT -> immediately IDLE, dmem_req_valid=0, rsp_valid=0; a new LW after reset completes normally.
